// File: rtl/div_ctrl.sv
// Divide-request sequencer between the EX stage, an iterative divider and the register-file write port.
// Optional result reuse for repeated operands is enabled with the DIV_RESULT_CACHE_EN macro.
module div_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_req_i,
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          flush_i,
    output logic          div_en_o,
    output logic          div_signed_o,
    output logic [DW-1:0] div_dividend_o,
    output logic [DW-1:0] div_divisor_o,
    input  logic [DW-1:0] div_quot_i,
    input  logic [DW-1:0] div_rem_i,
    input  logic          div_done_i,
    input  logic          div_busy_i,
    output logic          stall_o,
    output logic          wb_en_o,
    output logic [4:0]    wb_addr_o,
    output logic [DW-1:0] wb_data_o,
    output logic [2:0]    state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [DW-1:0] ONES    = '1;
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    // Handshake: a request is taken only in IDLE, when div_req_i is high with a
    // divide-class funct3 and no flush is present in that same cycle.
    logic [2:0]    state;
    logic          sel_rem;
    logic          accept;
    logic          req_signed;
    logic          is_div0;
    logic          is_ovf;
    logic          cache_hit;
    logic          bypass;
    logic [DW-1:0] byp_quot;
    logic [DW-1:0] byp_rem;
    logic [DW-1:0] byp_data;

`ifdef DIV_RESULT_CACHE_EN
    logic          c_valid;
    logic          c_signed;
    logic [DW-1:0] c_dividend;
    logic [DW-1:0] c_divisor;
    logic [DW-1:0] c_quot;
    logic [DW-1:0] c_rem;

    assign cache_hit = c_valid && (rs1_data_i == c_dividend) &&
                       (rs2_data_i == c_divisor) && (req_signed == c_signed);
`else
    assign cache_hit = 1'b0;
`endif

    assign accept     = (state == S_IDLE) && div_req_i && funct3_i[2] && !flush_i;
    assign req_signed = ~funct3_i[0];
    assign is_div0    = (rs2_data_i == '0);
    assign is_ovf     = req_signed && (rs1_data_i == MIN_NEG) && (rs2_data_i == ONES);
    assign bypass     = is_div0 || is_ovf || cache_hit;

    // Special cases take priority over reuse; neither is ever stored for reuse.
    always_comb begin
        byp_quot = '0;
        byp_rem  = '0;
        if (is_div0) begin
            byp_quot = ONES;
            byp_rem  = rs1_data_i;
        end else if (is_ovf) begin
            byp_quot = rs1_data_i;
            byp_rem  = '0;
        end
`ifdef DIV_RESULT_CACHE_EN
        else if (cache_hit) begin
            byp_quot = c_quot;
            byp_rem  = c_rem;
        end
`endif
    end

    assign byp_data = funct3_i[1] ? byp_rem : byp_quot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            sel_rem        <= 1'b0;
            div_signed_o   <= 1'b0;
            div_dividend_o <= '0;
            div_divisor_o  <= '0;
            wb_addr_o      <= '0;
            wb_data_o      <= '0;
`ifdef DIV_RESULT_CACHE_EN
            c_valid    <= 1'b0;
            c_signed   <= 1'b0;
            c_dividend <= '0;
            c_divisor  <= '0;
            c_quot     <= '0;
            c_rem      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_dividend_o <= rs1_data_i;
                        div_divisor_o  <= rs2_data_i;
                        div_signed_o   <= req_signed;
                        sel_rem        <= funct3_i[1];
                        wb_addr_o      <= rd_addr_i;
                        if (bypass) begin
                            wb_data_o <= byp_data;
                            state     <= S_WB;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (flush_i) begin
                        state <= S_DRAIN;
`ifdef DIV_RESULT_CACHE_EN
                        c_valid <= 1'b0;
`endif
                    end else if (state == S_ISSUE) begin
                        state <= S_WAIT;
                    end else if (div_done_i) begin
                        wb_data_o <= sel_rem ? div_rem_i : div_quot_i;
                        state     <= S_WB;
`ifdef DIV_RESULT_CACHE_EN
                        c_valid    <= 1'b1;
                        c_signed   <= div_signed_o;
                        c_dividend <= div_dividend_o;
                        c_divisor  <= div_divisor_o;
                        c_quot     <= div_quot_i;
                        c_rem      <= div_rem_i;
`endif
                    end
                end
                S_WB: state <= S_IDLE;
                // The aborted divide keeps running; wait until it has fully retired.
                S_DRAIN: begin
                    if (!div_busy_i && !div_done_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign div_en_o  = (state == S_ISSUE);
    assign wb_en_o   = (state == S_WB) && !flush_i;
    assign stall_o   = accept || (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
    assign state_dbg = state;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: behavioural divider model, writeback monitor and scenario tasks.
module tb_div_ctrl;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          div_req_i = 1'b0;
    logic [2:0]    funct3_i = 3'b000;
    logic [DW-1:0] rs1_data_i = '0;
    logic [DW-1:0] rs2_data_i = '0;
    logic [4:0]    rd_addr_i = '0;
    logic          flush_i = 1'b0;
    logic          div_en_o, div_signed_o, stall_o, wb_en_o;
    logic [DW-1:0] div_dividend_o, div_divisor_o, wb_data_o;
    logic [DW-1:0] div_quot_i = '0;
    logic [DW-1:0] div_rem_i = '0;
    logic          div_done_i = 1'b0;
    logic          div_busy_i = 1'b0;
    logic [4:0]    wb_addr_o;
    logic [2:0]    state_dbg;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    div_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .div_req_i(div_req_i), .funct3_i(funct3_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .div_en_o(div_en_o), .div_signed_o(div_signed_o),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_quot_i(div_quot_i), .div_rem_i(div_rem_i), .div_done_i(div_done_i),
        .div_busy_i(div_busy_i), .stall_o(stall_o), .wb_en_o(wb_en_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: busy 3 cycles after the start pulse, then done held for 2 cycles.
    int busy_cnt = 0, done_hold = 0, en_cnt = 0, done_cyc = 0;
    logic [DW-1:0] m_q, m_r;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0; done_hold = 0; div_busy_i = 1'b0; div_done_i = 1'b0;
        end else if (div_en_o) begin
            en_cnt++;
            if (div_divisor_o == '0) begin
                m_q = '1; m_r = div_dividend_o;
            end else if (div_signed_o) begin
                m_q = $signed(div_dividend_o) / $signed(div_divisor_o);
                m_r = $signed(div_dividend_o) % $signed(div_divisor_o);
            end else begin
                m_q = div_dividend_o / div_divisor_o;
                m_r = div_dividend_o % div_divisor_o;
            end
            busy_cnt = 3; done_hold = 0; div_busy_i = 1'b1; div_done_i = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                div_busy_i = 1'b0; div_done_i = 1'b1; done_hold = 2; done_cyc = cyc;
                div_quot_i = m_q; div_rem_i = m_r;
            end
        end else if (done_hold > 0) begin
            done_hold--;
            if (done_hold == 0) div_done_i = 1'b0;
        end
    end

    // Writeback monitor
    int wb_cnt = 0, wb_cyc = 0;
    logic [DW-1:0] wb_data_seen = '0;
    logic [4:0]    wb_addr_seen = '0;
    logic          wb_stall_seen = 1'b0, wb_signed_seen = 1'b0;
    always @(negedge clk) begin
        #2;
        if (wb_en_o === 1'b1) begin
            wb_cnt++; wb_cyc = cyc; wb_data_seen = wb_data_o; wb_addr_seen = wb_addr_o;
            wb_stall_seen = stall_o; wb_signed_seen = div_signed_o;
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] rd, output int en_delta, output int lat_req,
                         output int lat_done, output logic stall_req, output logic timed_out);
        int en0, wb0, rc;
        @(negedge clk);
        en0 = en_cnt; wb0 = wb_cnt; rc = cyc;
        div_req_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        #1 stall_req = stall_o;
        @(negedge clk);
        div_req_i = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (wb_cnt != wb0) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
        en_delta = en_cnt - en0;
        lat_req  = wb_cyc - rc;
        lat_done = wb_cyc - done_cyc;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({div_en_o, div_signed_o, stall_o, wb_en_o, wb_addr_o} !== 9'd0) $display("FAIL reset_ctrl: got %b want 0", {div_en_o, div_signed_o, stall_o, wb_en_o, wb_addr_o}); else passed++;
        checks++; if ({div_dividend_o, div_divisor_o, wb_data_o} !== '0) $display("FAIL reset_data: got %h want 0", {div_dividend_o, div_divisor_o, wb_data_o}); else passed++;
        checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_div_basic();
        int en_d, lr, ld; logic st, to;
        do_op(3'b100, 32'd100, 32'd7, 5'd5, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0) $display("FAIL div_basic_timeout: got timeout want wb"); else passed++;
        checks++; if (st !== 1'b1) $display("FAIL div_basic_stall_req: got %b want 1", st); else passed++;
        checks++; if (en_d !== 1) $display("FAIL div_basic_en_pulses: got %0d want 1", en_d); else passed++;
        checks++; if (wb_data_seen !== 32'd14) $display("FAIL div_basic_data: got %h want %h", wb_data_seen, 32'd14); else passed++;
        checks++; if (wb_addr_seen !== 5'd5) $display("FAIL div_basic_addr: got %0d want 5", wb_addr_seen); else passed++;
        checks++; if (ld !== 1) $display("FAIL div_basic_latency: got %0d want 1", ld); else passed++;
        checks++; if (wb_stall_seen !== 1'b0) $display("FAIL div_basic_stall_wb: got %b want 0", wb_stall_seen); else passed++;
    endtask

    task automatic test_signed_unsigned();
        int en_d, lr, ld; logic st, to;
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'hFFFF_FFFF) $display("FAIL rem_signed: got %h to=%b want ffffffff", wb_data_seen, to); else passed++;
        checks++; if (wb_signed_seen !== 1'b1) $display("FAIL rem_signed_mode: got %b want 1", wb_signed_seen); else passed++;
        do_op(3'b101, 32'hFFFF_FFFF, 32'd2, 5'd7, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'h7FFF_FFFF) $display("FAIL divu: got %h to=%b want 7fffffff", wb_data_seen, to); else passed++;
        checks++; if (wb_signed_seen !== 1'b0) $display("FAIL divu_mode: got %b want 0", wb_signed_seen); else passed++;
    endtask

    task automatic test_div_zero();
        int en_d, lr, ld; logic st, to;
        do_op(3'b100, 32'd5, 32'd0, 5'd8, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'hFFFF_FFFF) $display("FAIL div_zero_q: got %h to=%b want ffffffff", wb_data_seen, to); else passed++;
        checks++; if (en_d !== 0) $display("FAIL div_zero_en: got %0d want 0", en_d); else passed++;
        checks++; if (lr !== 1) $display("FAIL div_zero_latency: got %0d want 1", lr); else passed++;
        do_op(3'b111, 32'd5, 32'd0, 5'd8, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd5 || en_d !== 0) $display("FAIL remu_zero: got %h en=%0d want 5 en=0", wb_data_seen, en_d); else passed++;
    endtask

    task automatic test_overflow();
        int en_d, lr, ld; logic st, to;
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'h8000_0000 || en_d !== 0 || lr !== 1) $display("FAIL ovf_div: got %h en=%0d lat=%0d want 80000000 en=0 lat=1", wb_data_seen, en_d, lr); else passed++;
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd0 || en_d !== 0) $display("FAIL ovf_rem: got %h en=%0d want 0 en=0", wb_data_seen, en_d); else passed++;
        // Same operands unsigned are an ordinary divide.
        do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd0 || en_d !== 1) $display("FAIL ovf_divu: got %h en=%0d want 0 en=1", wb_data_seen, en_d); else passed++;
    endtask

    task automatic test_ignored_and_idle_flush();
        int wb0;
        wb0 = wb_cnt;
        @(negedge clk);
        div_req_i = 1'b1; funct3_i = 3'b000; rs1_data_i = 32'd9; rs2_data_i = 32'd3;
        #1;
        checks++; if (stall_o !== 1'b0) $display("FAIL ignored_stall: got %b want 0", stall_o); else passed++;
        @(negedge clk);
        funct3_i = 3'b100; rs2_data_i = 32'd0; flush_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0 || state_dbg !== 3'd0) $display("FAIL idle_flush: stall=%b state=%0d want 0/0", stall_o, state_dbg); else passed++;
        @(negedge clk);
        div_req_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checks++; if (wb_cnt !== wb0) $display("FAIL ignored_wb: got %0d writes want 0", wb_cnt - wb0); else passed++;
    endtask

    task automatic test_flush_wb();
        int wb0;
        wb0 = wb_cnt;
        @(negedge clk);
        div_req_i = 1'b1; funct3_i = 3'b100; rs1_data_i = 32'd5; rs2_data_i = 32'd0; rd_addr_i = 5'd13;
        @(negedge clk);
        div_req_i = 1'b0; flush_i = 1'b1;
        #1;
        checks++; if (state_dbg !== 3'd3 || wb_en_o !== 1'b0) $display("FAIL flush_wb: state=%0d wb_en=%b want 3/0", state_dbg, wb_en_o); else passed++;
        @(negedge clk);
        flush_i = 1'b0;
        #3;
        checks++; if (wb_cnt !== wb0 || state_dbg !== 3'd0) $display("FAIL flush_wb_after: writes=%0d state=%0d want 0/0", wb_cnt - wb0, state_dbg); else passed++;
    endtask

    task automatic test_flush_wait();
        int en0, wb0, en_d, lr, ld; logic st, to, seen;
        en0 = en_cnt; wb0 = wb_cnt;
        @(negedge clk);
        div_req_i = 1'b1; funct3_i = 3'b100; rs1_data_i = 32'd1000; rs2_data_i = 32'd9; rd_addr_i = 5'd3;
        @(negedge clk);
        div_req_i = 1'b0;
        #1;
        checks++; if (div_en_o !== 1'b1) $display("FAIL flush_issue_en: got %b want 1", div_en_o); else passed++;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        checks++; if (state_dbg !== 3'd4 || stall_o !== 1'b1) $display("FAIL flush_drain: state=%0d stall=%b want 4/1", state_dbg, stall_o); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (div_done_i) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++; if (seen !== 1'b1 || stall_o !== 1'b1) $display("FAIL flush_drain_done: done_seen=%b stall=%b want 1/1", seen, stall_o); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!div_done_i) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        checks++; if (seen !== 1'b1 || stall_o !== 1'b0 || state_dbg !== 3'd0) $display("FAIL flush_to_idle: done_fell=%b stall=%b state=%0d want 1/0/0", seen, stall_o, state_dbg); else passed++;
        checks++; if (wb_cnt !== wb0 || en_cnt - en0 !== 1) $display("FAIL flush_no_wb: writes=%0d en=%0d want 0/1", wb_cnt - wb0, en_cnt - en0); else passed++;
        do_op(3'b101, 32'd20, 32'd3, 5'd9, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd6 || wb_addr_seen !== 5'd9) $display("FAIL flush_next: got %h rd=%0d want 6 rd=9", wb_data_seen, wb_addr_seen); else passed++;
    endtask

    task automatic test_reset_mid();
        int wb0, en_d, lr, ld; logic st, to;
        @(negedge clk);
        div_req_i = 1'b1; funct3_i = 3'b100; rs1_data_i = 32'd77; rs2_data_i = 32'd5; rd_addr_i = 5'd14;
        @(negedge clk);
        div_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1; wb0 = wb_cnt;
        @(negedge clk);
        #1;
        checks++; if (state_dbg !== 3'd0 || stall_o !== 1'b0 || div_dividend_o !== '0 || wb_data_o !== '0 || wb_addr_o !== '0) $display("FAIL reset_mid: state=%0d stall=%b dvd=%h wbd=%h want all 0", state_dbg, stall_o, div_dividend_o, wb_data_o); else passed++;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        checks++; if (wb_cnt !== wb0) $display("FAIL reset_mid_wb: got %0d writes want 0", wb_cnt - wb0); else passed++;
        do_op(3'b111, 32'd20, 32'd3, 5'd15, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd2 || en_d !== 1) $display("FAIL reset_mid_next: got %h en=%0d want 2 en=1", wb_data_seen, en_d); else passed++;
    endtask

    task automatic test_back_to_back();
        int en_d, lr, ld; logic st, to;
        do_op(3'b100, 32'd100, 32'd7, 5'd20, en_d, lr, ld, st, to);
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd14 || en_d !== 1) $display("FAIL b2b_div: got %h en=%0d want 14 en=1", wb_data_seen, en_d); else passed++;
        do_op(3'b110, 32'd100, 32'd7, 5'd21, en_d, lr, ld, st, to);
`ifdef DIV_RESULT_CACHE_EN
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd2 || en_d !== 0 || lr !== 1) $display("FAIL b2b_rem_cached: got %h en=%0d lat=%0d want 2 en=0 lat=1", wb_data_seen, en_d, lr); else passed++;
`else
        checks++; if (to !== 1'b0 || wb_data_seen !== 32'd2 || en_d !== 1 || ld !== 1) $display("FAIL b2b_rem: got %h en=%0d lat=%0d want 2 en=1 lat=1", wb_data_seen, en_d, ld); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_signed_unsigned();
        test_div_zero();
        test_overflow();
        test_ignored_and_idle_flush();
        test_flush_wb();
        test_flush_wait();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
